// File: rtl/factorial_engine_if.sv
// Start/done handshake and result bus of the iterative factorial unit.
// The controller side uses the master modport, the engine uses the slave modport.
interface factorial_engine_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21
);
    logic             start;
    logic [IN_W-1:0]  ain;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  counter;
    logic             overflow;
    logic [OUT_W-1:0] aout;

    modport master (
        output start, ain,
        input  busy, done, counter, overflow, aout
    );

    modport slave (
        input  start, ain,
        output busy, done, counter, overflow, aout
    );
endinterface

// File: rtl/factorial_engine.sv
// Iterative factorial: one acc*counter multiply per clock with a sticky overflow flag.
// Define FACT_SATURATE_EN to stop on overflow with an all-ones result instead of wrapping.
module factorial_engine #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21
) (
    input  logic               clock,
    input  logic               reset,
    factorial_engine_if.slave  bus
);
    localparam int P_W = OUT_W + IN_W;
    localparam logic [IN_W-1:0]  CNT_ONE  = IN_W'(1'b1);
    localparam logic [OUT_W-1:0] ACC_ONE  = OUT_W'(1'b1);
    localparam logic [OUT_W-1:0] ACC_SAT  = {OUT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [OUT_W-1:0] acc_r, acc_s;
    logic [IN_W-1:0]  cnt_r, cnt_s;
    logic             ovf_r, ovf_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [OUT_W-1:0] aout_r, aout_s;
    logic [P_W-1:0]   prod_s;
    logic             prod_fits_s;

    // Full-width product; the high part tells whether it still fits the accumulator
    assign prod_s      = P_W'(acc_r) * P_W'(cnt_r);
    assign prod_fits_s = (prod_s[P_W-1:OUT_W] == {IN_W{1'b0}});

    // Next-state and datapath decode
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        aout_s  = aout_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    acc_s   = ACC_ONE;
                    cnt_s   = bus.ain;
                    ovf_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r <= CNT_ONE) begin
                    aout_s  = acc_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else if (prod_fits_s) begin
                    acc_s = prod_s[OUT_W-1:0];
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    ovf_s = 1'b1;
`ifdef FACT_SATURATE_EN
                    // Counter is left at the factor that overflowed
                    aout_s  = ACC_SAT;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
`else
                    acc_s = prod_s[OUT_W-1:0];
                    cnt_s = cnt_r - CNT_ONE;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            acc_r   <= ACC_ONE;
            cnt_r   <= {IN_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            aout_r  <= {OUT_W{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            aout_r  <= aout_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.counter  = cnt_r;
    assign bus.overflow = ovf_r;
    assign bus.aout     = aout_r;
endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine: vector table through a scoreboard,
// plus sequences for counter stepping, ignored start, held start and mid-run reset.
module tb_factorial_engine;
    localparam int IN_W  = 16;
    localparam int OUT_W = 21;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    factorial_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();
    factorial_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [IN_W-1:0]  ain;
        logic [OUT_W-1:0] aout;
        logic             ovf;
        int               lat;
        logic [IN_W-1:0]  cnt;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_aout"},     bus.aout,     0);
        chk({tag, "_counter"},  bus.counter,  0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_done"},     bus.done,     0);
        chk({tag, "_busy"},     bus.busy,     0);
    endtask

    // Pulse start for one edge (E0) and queue the expected result
    task automatic launch(input vec_t v);
        bus.start = 1'b1;
        bus.ain   = v.ain;
        tick();
        bus.start = 1'b0;
        sb.push_back(v);
        chk($sformatf("busy_at_E0_n%0d", v.ain), bus.busy, 1);
    endtask

    // Wait for done (bounded), pop the scoreboard and compare; base = edges already consumed
    task automatic await_done(input string tag, input int base);
        bit   seen;
        int   lat;
        vec_t v;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = base + i;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done actual=done expected=none", tag);
        end else begin
            v = sb.pop_front();
            chk({tag, "_aout"},     bus.aout,     v.aout);
            chk({tag, "_overflow"}, bus.overflow, v.ovf);
            chk({tag, "_counter"},  bus.counter,  v.cnt);
            chk({tag, "_latency"},  lat,          v.lat);
            chk({tag, "_busy_low"}, bus.busy,     0);
            tick();
            chk({tag, "_done_one_cycle"}, bus.done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   extra_done;
        vec_t v;

        vecs[0] = '{16'd4,  21'd24,     1'b0, 4, 16'd1};
        vecs[1] = '{16'd0,  21'd1,      1'b0, 1, 16'd0};
        vecs[2] = '{16'd1,  21'd1,      1'b0, 1, 16'd1};
        vecs[3] = '{16'd9,  21'd362880, 1'b0, 9, 16'd1};
`ifdef FACT_SATURATE_EN
        vecs[4] = '{16'd10, 21'd2097151, 1'b1, 9, 16'd2};
`else
        vecs[4] = '{16'd10, 21'd1531648, 1'b1, 10, 16'd1};
`endif
        vecs[5] = '{16'd3,  21'd6,      1'b0, 3, 16'd1};
        vecs[6] = '{16'd8,  21'd40320,  1'b0, 8, 16'd1};
        vecs[7] = '{16'd2,  21'd2,      1'b0, 2, 16'd1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.ain   = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();
        chk_reset_vals("idle_hold");

        for (int k = 0; k < 8; k++) begin
            launch(vecs[k]);
            await_done($sformatf("vec_n%0d", vecs[k].ain), 0);
        end

        // Counter steps 4,3,2,1 for n=4
        v = '{16'd4, 21'd24, 1'b0, 4, 16'd1};
        launch(v);
        chk("step_E0_counter", bus.counter, 4);
        for (int k = 3; k >= 1; k--) begin
            tick();
            chk($sformatf("step_counter_%0d", k), bus.counter, k);
            chk($sformatf("step_done_low_%0d", k), bus.done, 0);
        end
        await_done("step_n4", 3);

        // Start during CALC is ignored and not queued
        v = '{16'd6, 21'd720, 1'b0, 6, 16'd1};
        launch(v);
        tick();
        bus.start = 1'b1;
        bus.ain   = 16'd3;
        tick();
        bus.start = 1'b0;
        await_done("ignored_start", 2);
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) extra_done++;
        end
        chk("ignored_start_no_extra_done", extra_done, 0);
        chk("ignored_start_idle", bus.busy, 0);

        // Start held through done restarts only on the following edge
        v = '{16'd2, 21'd2, 1'b0, 2, 16'd1};
        bus.start = 1'b1;
        bus.ain   = 16'd2;
        tick();
        sb.push_back(v);
        chk("held_busy_E0", bus.busy, 1);
        await_done("held_first", 0);
        chk("held_restart_busy", bus.busy, 1);
        chk("held_restart_counter", bus.counter, 2);
        sb.push_back(v);
        bus.start = 1'b0;
        await_done("held_second", 0);

        // Reset mid-run aborts asynchronously, no done afterwards
        v = '{16'd5, 21'd120, 1'b0, 5, 16'd1};
        launch(v);
        tick();
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) extra_done++;
        end
        chk("post_reset_no_done", extra_done, 0);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_aout", bus.aout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
